// File: rtl/demux8_deserializer.sv
// Registered 1-to-8 demultiplexer / deserializer: reassembles serial bits into a byte,
// either by an internal slot counter (auto mode) or by an explicit slot index (addressed mode).
module demux8_deserializer #(
   parameter int unsigned REVERSE   = 0,
   parameter int unsigned DUP_CHECK = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       din,
   input  logic       din_valid,
   input  logic       addr_mode,
   input  logic [2:0] sel,
   input  logic       clear,
   output logic [7:0] Q,
   output logic       byte_done,
   output logic [2:0] bit_idx,
   output logic       busy,
   output logic       dup_err
);

   logic [7:0] shadow_q, shadow_d;
   logic [7:0] wmask_q, wmask_d;
   logic [7:0] q_q, q_d;
   logic [2:0] cnt_q, cnt_d;
   logic       mode_q;
   logic       byte_done_q, byte_done_d;
   logic       dup_err_q, dup_err_d;

   logic       abort;
   logic [2:0] slot;
   logic [7:0] merged;
   logic [7:0] wmask_set;
   logic [3:0] fill_cnt;

   always_comb begin
      // A mode change behaves exactly like clear so a frame never mixes both slot schemes.
      abort     = clear || (addr_mode != mode_q);
      slot      = (REVERSE != 0) ? (3'd7 - cnt_q) : cnt_q;
      merged    = shadow_q;
      wmask_set = wmask_q;
      if (mode_q) begin
         merged[sel]    = din;
         wmask_set[sel] = 1'b1;
      end else begin
         merged[slot] = din;
      end

      shadow_d    = shadow_q;
      wmask_d     = wmask_q;
      cnt_d       = cnt_q;
      q_d         = q_q;
      dup_err_d   = dup_err_q;
      byte_done_d = 1'b0;

      if (abort) begin
         shadow_d = 8'h00;
         wmask_d  = 8'h00;
         cnt_d    = 3'd0;
      end else if (din_valid) begin
         if (!mode_q) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               q_d         = merged;
               byte_done_d = 1'b1;
               shadow_d    = 8'h00;
            end else begin
               shadow_d = merged;
            end
         end else begin
            if (wmask_q[sel] && (DUP_CHECK != 0)) begin
               dup_err_d = 1'b1;
            end
            if (&wmask_set) begin
               q_d         = merged;
               byte_done_d = 1'b1;
               shadow_d    = 8'h00;
               wmask_d     = 8'h00;
            end else begin
               shadow_d = merged;
               wmask_d  = wmask_set;
            end
         end
      end
   end

   always_comb begin
      fill_cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         fill_cnt = fill_cnt + {3'd0, wmask_q[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q    <= 8'h00;
         wmask_q     <= 8'h00;
         cnt_q       <= 3'd0;
         q_q         <= 8'h00;
         byte_done_q <= 1'b0;
         dup_err_q   <= 1'b0;
         mode_q      <= addr_mode;
      end else begin
         shadow_q    <= shadow_d;
         wmask_q     <= wmask_d;
         cnt_q       <= cnt_d;
         q_q         <= q_d;
         byte_done_q <= byte_done_d;
         dup_err_q   <= dup_err_d;
         mode_q      <= addr_mode;
      end
   end

   assign Q         = q_q;
   assign byte_done = byte_done_q;
   assign bit_idx   = mode_q ? fill_cnt[2:0] : cnt_q;
   assign busy      = mode_q ? (|wmask_q) : (|cnt_q);
   assign dup_err   = (DUP_CHECK != 0) ? dup_err_q : 1'b0;

endmodule

// File: tb/tb_demux8_deserializer.sv
// Scoreboard bench for demux8_deserializer: two instances (REVERSE=0/DUP_CHECK=1 and
// REVERSE=1/DUP_CHECK=0) share one directed stimulus stream.
module tb_demux8_deserializer;

   logic       clk = 1'b0;
   logic       reset, din, din_valid, addr_mode, clear;
   logic [2:0] sel;

   logic [7:0] q0, q1;
   logic       done0, done1, busy0, busy1, dup0, dup1;
   logic [2:0] idx0, idx1;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [7:0] exp0[$];
   logic [7:0] exp1[$];
   int         done_cyc[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   demux8_deserializer #(.REVERSE(0), .DUP_CHECK(1)) dut0 (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .addr_mode(addr_mode),
      .sel(sel), .clear(clear), .Q(q0), .byte_done(done0), .bit_idx(idx0), .busy(busy0),
      .dup_err(dup0)
   );

   demux8_deserializer #(.REVERSE(1), .DUP_CHECK(0)) dut1 (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .addr_mode(addr_mode),
      .sel(sel), .clear(clear), .Q(q1), .byte_done(done1), .bit_idx(idx1), .busy(busy1),
      .dup_err(dup1)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every byte_done pulse pops the oldest expected byte for that instance.
   always @(negedge clk) begin
      if (done0) begin
         done_cyc.push_back(cyc);
         n_cmp++;
         if (exp0.size() == 0) begin
            n_err++;
            $display("FAIL dut0 unexpected byte_done: got Q=%h expected no pulse", q0);
         end else begin
            logic [7:0] e;
            e = exp0.pop_front();
            if (q0 !== e) begin
               n_err++;
               $display("FAIL dut0 Q: got %h expected %h", q0, e);
            end
         end
      end
      if (done1) begin
         n_cmp++;
         if (exp1.size() == 0) begin
            n_err++;
            $display("FAIL dut1 unexpected byte_done: got Q=%h expected no pulse", q1);
         end else begin
            logic [7:0] e;
            e = exp1.pop_front();
            if (q1 !== e) begin
               n_err++;
               $display("FAIL dut1 Q: got %h expected %h", q1, e);
            end
         end
      end
   end

   task automatic push(input logic [7:0] e0, input logic [7:0] e1);
      exp0.push_back(e0);
      exp1.push_back(e1);
   endtask

   // Leaves din_valid high so consecutive calls are back-to-back strobes.
   task automatic drive(input logic b, input logic [2:0] s);
      din       = b;
      sel       = s;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      din_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic stream(input logic [7:0] bits);
      for (int i = 0; i < 8; i++) drive(bits[i], 3'd0);
   endtask

   task automatic chk_status(input string tag, input logic [2:0] idx, input logic bsy);
      @(negedge clk);
      chk({tag, " bit_idx0"}, {5'd0, idx0}, {5'd0, idx});
      chk({tag, " bit_idx1"}, {5'd0, idx1}, {5'd0, idx});
      chk({tag, " busy0"}, {7'd0, busy0}, {7'd0, bsy});
      chk({tag, " busy1"}, {7'd0, busy1}, {7'd0, bsy});
   endtask

   task automatic chk_reset(input string tag);
      @(negedge clk);
      chk({tag, " Q0"}, q0, 8'h00);
      chk({tag, " Q1"}, q1, 8'h00);
      chk({tag, " done0"}, {7'd0, done0}, 8'h00);
      chk({tag, " dup0"}, {7'd0, dup0}, 8'h00);
      chk({tag, " dup1"}, {7'd0, dup1}, 8'h00);
      chk_status(tag, 3'd0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] order[8];
      reset = 1'b1; din = 1'b0; din_valid = 1'b0; addr_mode = 1'b0; clear = 1'b0; sel = 3'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk_reset("reset");

      // Stream bits are listed first-received in bit 0: 1,0,1,1,0,0,1,0 then eight ones.
      push(8'h4D, 8'hB2);
      push(8'hFF, 8'hFF);
      stream(8'b0100_1101);
      stream(8'hFF);
      idle();
      chk_status("auto done", 3'd0, 1'b0);
      chk("auto hold Q0", q0, 8'hFF);

      // Abort: prior byte 0x4D, then 5 bits, then clear with a simultaneous strobe.
      push(8'h4D, 8'hB2);
      stream(8'b0100_1101);
      for (int i = 0; i < 5; i++) drive(1'b1, 3'd0);
      chk_status("partial", 3'd5, 1'b1);
      din = 1'b1; clear = 1'b1; din_valid = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0; din_valid = 1'b0;
      chk_status("clear", 3'd0, 1'b0);
      chk("clear hold Q0", q0, 8'h4D);
      chk("clear hold Q1", q1, 8'hB2);
      // Fresh bits 0,1,1,0,1,0,0,1.
      push(8'h96, 8'h69);
      stream(8'b1001_0110);

      // Mode change mid-frame: the strobe on the toggle cycle must be ignored.
      for (int i = 0; i < 3; i++) drive(1'b1, 3'd0);
      chk_status("pre toggle", 3'd3, 1'b1);
      addr_mode = 1'b1;
      drive(1'b1, 3'd0);
      din_valid = 1'b0;
      chk_status("toggle", 3'd0, 1'b0);

      order = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};
      push(8'h11, 8'h11);
      for (int i = 0; i < 8; i++) begin
         drive((order[i] == 3'd0) || (order[i] == 3'd4), order[i]);
         if (i == 3) chk_status("addr half", 3'd4, 1'b1);
      end
      idle();
      chk_status("addr done", 3'd0, 1'b0);
      chk("addr dup0", {7'd0, dup0}, 8'h00);

      // Duplicate slot 2: last write wins, dup_err only where DUP_CHECK is enabled.
      drive(1'b1, 3'd2);
      drive(1'b0, 3'd2);
      din_valid = 1'b0;
      @(negedge clk);
      chk("dup set dup0", {7'd0, dup0}, 8'h01);
      chk("dup set dup1", {7'd0, dup1}, 8'h00);
      chk("dup bit_idx0", {5'd0, idx0}, 8'h01);
      order = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      push(8'h00, 8'h00);
      for (int i = 0; i < 7; i++) drive(1'b0, order[i]);
      idle();
      chk("dup sticky dup0", {7'd0, dup0}, 8'h01);
      chk("dup sticky dup1", {7'd0, dup1}, 8'h00);
      chk("dup Q0", q0, 8'h00);

      // Reset mid addressed frame.
      for (int i = 0; i < 4; i++) drive(1'b1, 3'(i));
      din_valid = 1'b0;
      chk_status("pre reset", 3'd4, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk_reset("mid reset");

      repeat (3) idle();
      chk("dut0 pending", 8'(exp0.size()), 8'd0);
      chk("dut1 pending", 8'(exp1.size()), 8'd0);
      chk("pulse count", 8'(done_cyc.size()), 8'd6);
      if (done_cyc.size() >= 2) chk("pulse gap", 8'(done_cyc[1] - done_cyc[0]), 8'd8);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
